// File: rtl/led_pkg.sv
// Shared mode encoding and helpers for the LED pattern generator.
package led_pkg;

    localparam int unsigned MODE_W = 2;

    typedef logic [MODE_W-1:0] led_mode_t;

    localparam led_mode_t LED_OFF       = 2'd0;
    localparam led_mode_t LED_ON        = 2'd1;
    localparam led_mode_t LED_BLINK     = 2'd2;
    localparam led_mode_t LED_BLINK_INV = 2'd3;

    // LED level a channel starts from after a write or phase restart.
    function automatic logic start_val(input led_mode_t mode);
        return (mode == LED_ON) || (mode == LED_BLINK_INV);
    endfunction

    // Both blinking modes share the upper mode bit.
    function automatic logic is_blink(input led_mode_t mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Configuration port of the LED pattern generator (valid/ready handshake).
//   cfg_valid  : request from the board control logic
//   cfg_ready  : generator can accept a request this cycle
//   cfg_ch     : target channel
//   cfg_mode   : OFF / ON / BLINK / BLINK_INV
//   cfg_period : blink half-period in base ticks (0 behaves as 1)
interface led_pattern_gen_if #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned PER_W = 8
);
    import led_pkg::*;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    led_mode_t        cfg_mode;
    logic [PER_W-1:0] cfg_period;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_period,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_period,
        output cfg_ready
    );

endinterface

// File: rtl/led_channel.sv
// One LED channel: holds mode, half-period, tick counter and the LED level.
//   clk, rst   : clock, synchronous active-high reset
//   tick       : base tick strobe from the shared prescaler
//   sync       : restart the phase of this channel
//   wr_en      : write wr_mode/wr_period and restart the phase
//   led        : registered LED drive
module led_channel
    import led_pkg::*;
#(
    parameter int unsigned PER_W      = 8,
    parameter int unsigned DEF_PERIOD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             sync,
    input  logic             wr_en,
    input  led_mode_t        wr_mode,
    input  logic [PER_W-1:0] wr_period,
    output logic             led
);

    led_mode_t        mode_q,   mode_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] tcnt_q,   tcnt_d;
    logic             led_q,    led_d;
    logic [PER_W-1:0] last_c;

    // A zero half-period behaves as one tick.
    assign last_c = (period_q == '0) ? '0 : period_q - PER_W'(1);

    // Next state: write/sync restart the phase and take priority over the tick.
    always_comb begin
        mode_d   = mode_q;
        period_d = period_q;
        tcnt_d   = tcnt_q;
        led_d    = led_q;
        if (wr_en) begin
            mode_d   = wr_mode;
            period_d = wr_period;
        end
        if (wr_en || sync) begin
            tcnt_d = '0;
            led_d  = start_val(mode_d);
        end else if (tick && is_blink(mode_q)) begin
            if (tcnt_q == last_c) begin
                tcnt_d = '0;
                led_d  = ~led_q;
            end else begin
                tcnt_d = tcnt_q + PER_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= LED_OFF;
            period_q <= PER_W'(DEF_PERIOD);
            tcnt_q   <= '0;
            led_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            tcnt_q   <= tcnt_d;
            led_q    <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared prescaler, config handshake, N_LED channels.
//   clk, rst : clock, synchronous active-high reset
//   cfg      : configuration port (slave side)
//   sync     : one-cycle strobe, restarts the phase of every channel
//   tick     : registered one-cycle prescaler strobe
//   led      : LED drive, active-high
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned N_LED      = 4,
    parameter int unsigned CNT_TICK   = 50000000,
    parameter int unsigned PER_W      = 8,
    parameter int unsigned DEF_PERIOD = 1
) (
    input  logic             clk,
    input  logic             rst,
    led_pattern_gen_if.slave cfg,
    input  logic             sync,
    output logic             tick,
    output logic [N_LED-1:0] led
);

    localparam int unsigned CH_W  = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam int unsigned PRE_W = $clog2(CNT_TICK);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CNT_TICK - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;
    logic             ready_q, ready_d;
    logic             xfer_c;
    logic             ch_ok_c;
    logic [N_LED-1:0] wr_en_c;

    assign xfer_c  = cfg.cfg_valid && ready_q;
    // Out-of-range channels still complete the handshake but write nothing.
    assign ch_ok_c = 32'(cfg.cfg_ch) < N_LED;

    // Prescaler wrap and handshake next state.
    always_comb begin
        pre_d   = pre_q + PRE_W'(1);
        tick_d  = 1'b0;
        ready_d = ~xfer_c;
        if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Prescaler and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            tick_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            ready_q <= ready_d;
        end
    end

    assign tick          = tick_q;
    assign cfg.cfg_ready = ready_q;

    // Channel array.
    for (genvar i = 0; i < N_LED; i++) begin : g_ch
        assign wr_en_c[i] = xfer_c && ch_ok_c && (cfg.cfg_ch == CH_W'(i));

        led_channel #(
            .PER_W      (PER_W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick_q),
            .sync      (sync),
            .wr_en     (wr_en_c[i]),
            .wr_mode   (cfg.cfg_mode),
            .wr_period (cfg.cfg_period),
            .led       (led[i])
        );
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a tick-counting reference model pushes the
// expected outputs for every clock edge, a negedge monitor pops and compares them.
module tb_led_pattern_gen;
    import led_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned CNT = 4;
    localparam int unsigned PW  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sync = 1'b0;
    logic         tick;
    logic [N-1:0] led;
    logic         tick3;
    logic [2:0]   led3;

    led_pattern_gen_if #(.CH_W(2), .PER_W(PW)) cfg_if ();
    led_pattern_gen_if #(.CH_W(2), .PER_W(PW)) cfg3_if ();

    led_pattern_gen #(.N_LED(N), .CNT_TICK(CNT), .PER_W(PW), .DEF_PERIOD(1)) dut (
        .clk (clk), .rst (rst), .cfg (cfg_if.slave), .sync (sync), .tick (tick), .led (led)
    );

    // Three-channel instance: a 2-bit channel field can address a channel that does not exist.
    led_pattern_gen #(.N_LED(3), .CNT_TICK(CNT), .PER_W(PW), .DEF_PERIOD(1)) dut3 (
        .clk (clk), .rst (rst), .cfg (cfg3_if.slave), .sync (sync), .tick (tick3), .led (led3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] led;
        logic         tick;
        logic         ready;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b1;

    // Reference model: edges since reset, and per channel the ticks seen since the last restart.
    int e;
    bit m_ready, m_tick, m_xfer;
    int m_mode[N];
    int m_eff[N];
    int m_n[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_led(input int c);
        int s;
        if (m_mode[c] == 0) return 1'b0;
        if (m_mode[c] == 1) return 1'b1;
        s = (m_mode[c] == 3) ? 1 : 0;
        return 1'((s + m_n[c] / m_eff[c]) % 2);
    endfunction

    // One clock edge: update the model from the inputs the DUT samples, push expectation.
    task automatic step();
        exp_t x;
        @(posedge clk);
        m_xfer = 1'b0;
        if (rst) begin
            e = 0; m_ready = 1'b1; m_tick = 1'b0;
            for (int c = 0; c < N; c++) begin
                m_mode[c] = 0; m_eff[c] = 1; m_n[c] = 0;
            end
        end else begin
            bit tk;
            tk     = m_tick;
            m_xfer = cfg_if.cfg_valid && m_ready;
            for (int c = 0; c < N; c++) begin
                bit wr;
                wr = m_xfer && (int'(cfg_if.cfg_ch) == c);
                if (wr) begin
                    m_mode[c] = int'(cfg_if.cfg_mode);
                    m_eff[c]  = (cfg_if.cfg_period == 0) ? 1 : int'(cfg_if.cfg_period);
                end
                if (wr || sync) m_n[c] = 0;
                else if (tk)    m_n[c]++;
            end
            m_ready = !m_xfer;
            e++;
            m_tick = (e % CNT) == 0;
        end
        for (int c = 0; c < N; c++) x.led[c] = exp_led(c);
        x.tick  = m_tick;
        x.ready = m_ready;
        sb.push_back(x);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_cfg(input int ch, input int mode, input int per);
        int guard = 0;
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_ch     = 2'(ch);
        cfg_if.cfg_mode   = led_mode_t'(mode);
        cfg_if.cfg_period = 4'(per);
        do begin
            step();
            guard++;
        end while (!m_xfer && guard < 4);
        cfg_if.cfg_valid = 1'b0;
        if (!m_xfer) begin
            tests++; fails++;
            $display("FAIL cfg_timeout: ch %0d not accepted within %0d cycles", ch, guard);
        end
    endtask

    task automatic pulse_sync();
        sync = 1'b1; step(); sync = 1'b0;
    endtask

    // Monitor: compare every cycle's outputs against the oldest expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb_empty: no expectation queued at %0t", $time);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("led", 32'(led), 32'(x.led));
                chk("tick", 32'(tick), 32'(x.tick));
                chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'(x.ready));
            end
        end
    end

    initial begin
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_mode = LED_OFF; cfg_if.cfg_period = '0;
        cfg3_if.cfg_valid = 1'b0; cfg3_if.cfg_ch = '0; cfg3_if.cfg_mode = LED_OFF; cfg3_if.cfg_period = '0;

        rst = 1'b1; idle(3); rst = 1'b0;
        idle(40);                                   // free-running prescaler

        do_cfg(0, 2, 2); pulse_sync(); idle(40);    // 16-cycle square wave on ch0

        do_cfg(0, 2, 1); do_cfg(1, 3, 1); pulse_sync(); idle(100);   // complementary pair

        do_cfg(2, 2, 0); do_cfg(3, 2, 1); pulse_sync(); idle(30);    // period 0 vs 1

        do_cfg(2, 1, 5); idle(10);                  // ch2 ON

        // Transfer on ch0 during a tick cycle while ch1 keeps blinking.
        while ((e % CNT) != 0 || !m_ready) step();
        do_cfg(0, 2, 1); idle(20);

        // Transfer and sync in the same cycle.
        sync = 1'b1; do_cfg(3, 3, 2); sync = 1'b0; idle(20);

        // Randomised traffic including occasional sync and reset.
        for (int i = 0; i < 400; i++) begin
            cfg_if.cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_if.cfg_ch     = 2'($urandom_range(0, 3));
            cfg_if.cfg_mode   = led_mode_t'($urandom_range(0, 3));
            cfg_if.cfg_period = 4'($urandom_range(0, 3));
            sync = ($urandom_range(0, 19) == 0);
            rst  = ($urandom_range(0, 149) == 0);
            step();
        end
        cfg_if.cfg_valid = 1'b0; sync = 1'b0; rst = 1'b0;

        // Reset in the middle of blinking.
        do_cfg(0, 2, 1); do_cfg(1, 3, 2); idle(13);
        rst = 1'b1; step(); rst = 1'b0; idle(10);

        // Out-of-range channel on the three-channel instance.
        cfg3_if.cfg_valid = 1'b1; cfg3_if.cfg_ch = 2'd0; cfg3_if.cfg_mode = LED_ON; cfg3_if.cfg_period = 4'd1;
        step();
        cfg3_if.cfg_valid = 1'b0;
        chk("oob_setup_led", 32'(led3), 32'h1);
        chk("oob_setup_ready", 32'(cfg3_if.cfg_ready), 32'h0);
        step();
        chk("oob_ready_back", 32'(cfg3_if.cfg_ready), 32'h1);
        cfg3_if.cfg_valid = 1'b1; cfg3_if.cfg_ch = 2'd3; cfg3_if.cfg_mode = LED_BLINK_INV;
        step();
        cfg3_if.cfg_valid = 1'b0;
        chk("oob_led", 32'(led3), 32'h1);
        chk("oob_ready_drop", 32'(cfg3_if.cfg_ready), 32'h0);
        idle(12);
        chk("oob_led_later", 32'(led3), 32'h1);

        #8;
        mon_en = 1'b0;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
